vga_sprite_engine: RTL and testbench

- Downstream pixel stage behind the AHB VGA slave's 32-bit position register.
- Generates 640x480@60 Hz VGA timing from HCLK using a pixel-enable divider.
- Draws one solid square sprite at the commanded (x,y) over a solid background.
- Position is resampled once per frame so a mid-frame bus write never tears the image.

---
 rtl/vga_pkg.sv | 33 +++
 rtl/vga_timing_gen.sv | 66 ++++++
 rtl/vga_sprite_engine.sv | 105 ++++++++++
 tb/tb_vga_sprite_engine.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA definitions: default 640x480@60 timing, rgb12 packing and colour constants.
package vga_pkg;

  localparam int H_VIS   = 640;
  localparam int H_FP    = 16;
  localparam int H_SYNC  = 96;
  localparam int H_BP    = 48;
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

  localparam int V_VIS   = 480;
  localparam int V_FP    = 10;
  localparam int V_SYNC  = 2;
  localparam int V_BP    = 33;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // Colour word is {R,G,B}, 4 bits each, R in the top nibble.
  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam logic [11:0] SPRITE_RGB_DEF = 12'hF00;
  localparam logic [11:0] BG_RGB_DEF     = 12'h00F;
  localparam logic [11:0] BORDER_RGB     = 12'hFFF;
  localparam logic [11:0] BLANK_RGB      = 12'h000;

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-enable divider, h/v counters, sync/active flags and the per-frame latch strobe.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int H_VIS   = vga_pkg::H_VIS,
  parameter int H_FP    = vga_pkg::H_FP,
  parameter int H_SYNC  = vga_pkg::H_SYNC,
  parameter int H_BP    = vga_pkg::H_BP,
  parameter int V_VIS   = vga_pkg::V_VIS,
  parameter int V_FP    = vga_pkg::V_FP,
  parameter int V_SYNC  = vga_pkg::V_SYNC,
  parameter int V_BP    = vga_pkg::V_BP
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        pix_en,
  output logic [15:0] h_cnt,
  output logic [15:0] v_cnt,
  output logic        hs,
  output logic        vs,
  output logic        active,
  output logic        frame_start
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST   = 16'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST   = 16'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_VIS_W  = 16'(H_VIS);
  localparam logic [15:0] V_VIS_W  = 16'(V_VIS);
  localparam logic [15:0] HS_LO    = 16'(H_VIS + H_FP);
  localparam logic [15:0] HS_HI    = 16'(H_VIS + H_FP + H_SYNC);
  localparam logic [15:0] VS_LO    = 16'(V_VIS + V_FP);
  localparam logic [15:0] VS_HI    = 16'(V_VIS + V_FP + V_SYNC);

  logic [DW-1:0] div_cnt;

  assign pix_en = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      h_cnt   <= '0;
      v_cnt   <= '0;
    end else begin
      div_cnt <= pix_en ? '0 : div_cnt + 1'b1;
      if (pix_en) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 16'd1;
        end else begin
          h_cnt <= h_cnt + 16'd1;
        end
      end
    end
  end

  assign hs     = !((h_cnt >= HS_LO) && (h_cnt < HS_HI));
  assign vs     = !((v_cnt >= VS_LO) && (v_cnt < VS_HI));
  assign active = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);

  // Fires at the start of the first blank line, so a new position never lands mid-picture.
  assign frame_start = pix_en && (h_cnt == 16'd0) && (v_cnt == V_VIS_W);

endmodule

// File: rtl/vga_sprite_engine.sv
// Solid square sprite over solid background on VGA timing; position resampled once per frame.
// Optional build macro VGA_BORDER_EN draws a white one-pixel frame around the active area.
module vga_sprite_engine
  import vga_pkg::*;
#(
  parameter int          CLK_DIV     = 2,
  parameter int          H_VIS       = vga_pkg::H_VIS,
  parameter int          H_FP        = vga_pkg::H_FP,
  parameter int          H_SYNC      = vga_pkg::H_SYNC,
  parameter int          H_BP        = vga_pkg::H_BP,
  parameter int          V_VIS       = vga_pkg::V_VIS,
  parameter int          V_FP        = vga_pkg::V_FP,
  parameter int          V_SYNC      = vga_pkg::V_SYNC,
  parameter int          V_BP        = vga_pkg::V_BP,
  parameter int          SPRITE_SIZE = 32,
  parameter logic [11:0] SPRITE_RGB  = SPRITE_RGB_DEF,
  parameter logic [11:0] BG_RGB      = BG_RGB_DEF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] position,
  output logic [3:0]  vgaR,
  output logic [3:0]  vgaG,
  output logic [3:0]  vgaB,
  output logic        vgaHS,
  output logic        vgaVS
);

  localparam logic [15:0] X_MAX = 16'(H_VIS - SPRITE_SIZE);
  localparam logic [15:0] Y_MAX = 16'(V_VIS - SPRITE_SIZE);
  localparam logic [15:0] SIZE  = 16'(SPRITE_SIZE);

  logic        pix_en, hs, vs, active, frame_start;
  logic [15:0] h_cnt, v_cnt;
  logic [15:0] x_l, y_l;
  logic        hit;
  rgb12_t      rgb_d, rgb_q;
  logic        hs_q, vs_q;

  function automatic logic [15:0] clamp16(input logic [15:0] val, input logic [15:0] lim);
    return (val > lim) ? lim : val;
  endfunction

  vga_timing_gen #(
    .CLK_DIV (CLK_DIV),
    .H_VIS   (H_VIS),  .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS   (V_VIS),  .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
  ) u_timing (
    .clk         (HCLK),
    .rst_n       (HRESETn),
    .pix_en      (pix_en),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .hs          (hs),
    .vs          (vs),
    .active      (active),
    .frame_start (frame_start)
  );

  // x_l <= X_MAX keeps x_l+SIZE inside 16 bits, so the window test cannot wrap.
  assign hit = active
            && (h_cnt >= x_l) && (h_cnt < x_l + SIZE)
            && (v_cnt >= y_l) && (v_cnt < y_l + SIZE);

`ifdef VGA_BORDER_EN
  logic on_border;
  assign on_border = (h_cnt == 16'd0) || (h_cnt == 16'(H_VIS - 1))
                  || (v_cnt == 16'd0) || (v_cnt == 16'(V_VIS - 1));
`endif

  always_comb begin
    rgb_d = rgb12_t'(BLANK_RGB);
    if (active) begin
      rgb_d = hit ? rgb12_t'(SPRITE_RGB) : rgb12_t'(BG_RGB);
`ifdef VGA_BORDER_EN
      if (on_border) rgb_d = rgb12_t'(BORDER_RGB);
`endif
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      x_l   <= '0;
      y_l   <= '0;
      rgb_q <= rgb12_t'(BLANK_RGB);
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_en) begin
      if (frame_start) begin
        x_l <= clamp16(position[15:0],  X_MAX);
        y_l <= clamp16(position[31:16], Y_MAX);
      end
      rgb_q <= rgb_d;
      hs_q  <= hs;
      vs_q  <= vs;
    end
  end

  assign vgaR  = rgb_q.r;
  assign vgaG  = rgb_q.g;
  assign vgaB  = rgb_q.b;
  assign vgaHS = hs_q;
  assign vgaVS = vs_q;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Scoreboard bench for vga_sprite_engine on a shrunken 24x16-pixel frame (16x12 visible, 4x4 sprite).
module tb_vga_sprite_engine;

  localparam int CLK_DIV = 2;
  localparam int H_VIS = 16, H_FP = 2, H_SYNC = 4, H_BP = 2;
  localparam int V_VIS = 12, V_FP = 1, V_SYNC = 2, V_BP = 1;
  localparam int H_TOTAL = 24;
  localparam int FRAME_PIX = 24 * 16;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] position = 32'h0;
  logic [3:0]  vgaR, vgaG, vgaB;
  logic        vgaHS, vgaVS;

  vga_sprite_engine #(
    .CLK_DIV (CLK_DIV),
    .H_VIS (H_VIS), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_VIS (V_VIS), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .SPRITE_SIZE (4),
    .SPRITE_RGB (12'hF00),
    .BG_RGB (12'h00F)
  ) dut (
    .HCLK     (HCLK),
    .HRESETn  (HRESETn),
    .position (position),
    .vgaR     (vgaR),
    .vgaG     (vgaG),
    .vgaB     (vgaB),
    .vgaHS    (vgaHS),
    .vgaVS    (vgaVS)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string       name;
    int          cyc;
    logic [13:0] exp;
  } chk_t;

  chk_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc;

  // HCLK edges since reset release; output for pixel p is valid after edge 2p+2.
  always @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) cyc <= 0;
    else          cyc <= cyc + 1;

  function automatic int pc(input int f, input int h, input int v);
    return 2 * (f * FRAME_PIX + v * H_TOTAL + h) + 2;
  endfunction

  function automatic logic [13:0] obs();
    return {vgaR, vgaG, vgaB, vgaHS, vgaVS};
  endfunction

  task automatic check(input string name, input logic [13:0] got, input logic [13:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got rgb=%h hs=%b vs=%b, expected rgb=%h hs=%b vs=%b",
               name, got[13:2], got[1], got[0], exp[13:2], exp[1], exp[0]);
    end
  endtask

  task automatic px(input string name, input int f, input int h, input int v,
                    input logic [11:0] rgb, input logic hs, input logic vs);
    chk_t c;
    c.name = name;
    c.cyc  = pc(f, h, v);
    c.exp  = {rgb, hs, vs};
    q.push_back(c);
  endtask

  task automatic wait_cyc(input int target);
    for (int i = 0; i < 20000 && cyc < target; i++) @(negedge HCLK);
  endtask

  task automatic drain();
    for (int i = 0; i < 20000 && q.size() > 0; i++) @(negedge HCLK);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d checks still pending, required 0", q.size());
      q.delete();
    end
  endtask

  always @(negedge HCLK) begin
    if (HRESETn && q.size() > 0) begin
      if (q[0].cyc == cyc) begin
        check(q[0].name, obs(), q[0].exp);
        void'(q.pop_front());
      end else if (q[0].cyc < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: sample missed at cycle %0d, required cycle %0d", q[0].name, cyc, q[0].cyc);
        void'(q.pop_front());
      end
    end
  end

  initial begin
    position = 32'h0002_0003;
    HRESETn  = 1'b0;
    repeat (3) @(negedge HCLK);
    check("reset_state", obs(), {12'h000, 1'b1, 1'b1});

    // Frame 0: latched position still 0 from reset, sprite at origin; sync edges.
    px("f0_origin_sprite", 0,  0,  0, 12'hF00, 1'b1, 1'b1);
    px("f0_front_porch",   0, 17,  0, 12'h000, 1'b1, 1'b1);
    px("f0_hs_first_low",  0, 18,  0, 12'h000, 1'b0, 1'b1);
    px("f0_hs_last_low",   0, 21,  0, 12'h000, 1'b0, 1'b1);
    px("f0_hs_back_high",  0, 22,  0, 12'h000, 1'b1, 1'b1);
    px("f0_vblank_first",  0,  0, 12, 12'h000, 1'b1, 1'b1);
    px("f0_vs_first_low",  0,  0, 13, 12'h000, 1'b1, 1'b0);
    px("f0_hs_vs_low",     0, 19, 13, 12'h000, 1'b0, 1'b0);
    px("f0_vs_last_low",   0,  0, 14, 12'h000, 1'b1, 1'b0);
    px("f0_vs_back_high",  0,  0, 15, 12'h000, 1'b1, 1'b1);
    // Frame 1: sprite at x=3..6, y=2..5.
    px("f1_above_sprite",  1,  3,  1, 12'h00F, 1'b1, 1'b1);
    px("f1_left_of",       1,  2,  2, 12'h00F, 1'b1, 1'b1);
    px("f1_top_left",      1,  3,  2, 12'hF00, 1'b1, 1'b1);
    px("f1_right_of",      1,  7,  2, 12'h00F, 1'b1, 1'b1);
    px("f1_hblank",        1, 16,  2, 12'h000, 1'b1, 1'b1);
    px("f1_after_write",   1,  3,  5, 12'hF00, 1'b1, 1'b1);
    px("f1_bottom_right",  1,  6,  5, 12'hF00, 1'b1, 1'b1);
    px("f1_below_sprite",  1,  3,  6, 12'h00F, 1'b1, 1'b1);
    px("f1_new_spot_old",  1, 12,  8, 12'h00F, 1'b1, 1'b1);
    px("f1_vblank",        1,  0, 12, 12'h000, 1'b1, 1'b1);
    // Frame 2: position FFFF_FFFF clamps to x=12..15, y=8..11.
    px("f2_no_wrap_orig",  2,  0,  0, 12'h00F, 1'b1, 1'b1);
    px("f2_old_spot_gone", 2,  3,  2, 12'h00F, 1'b1, 1'b1);
    px("f2_above_clamp",   2, 15,  7, 12'h00F, 1'b1, 1'b1);
    px("f2_clamp_tl",      2, 12,  8, 12'hF00, 1'b1, 1'b1);
    px("f2_left_clamp",    2, 11, 11, 12'h00F, 1'b1, 1'b1);
    px("f2_clamp_br",      2, 15, 11, 12'hF00, 1'b1, 1'b1);
    px("f3_pre_reset",     3,  7,  6, 12'h00F, 1'b1, 1'b1);

    HRESETn = 1'b1;
    wait_cyc(pc(1, 0, 5));
    position = 32'hFFFF_FFFF;

    wait_cyc(pc(3, 7, 6));
    #1 HRESETn = 1'b0;
    #1 check("async_reset_outputs", obs(), {12'h000, 1'b1, 1'b1});
    repeat (3) @(negedge HCLK);
    check("held_reset_outputs", obs(), {12'h000, 1'b1, 1'b1});
    if (q.size() > 0) drain();

    // After restart the latch is back to 0 and counters begin at (0,0).
    px("rst_origin_sprite", 0,  0,  0, 12'hF00, 1'b1, 1'b1);
    px("rst_bg_after",      0,  4,  0, 12'h00F, 1'b1, 1'b1);
    px("rst_hs_low",        0, 18,  0, 12'h000, 1'b0, 1'b1);
    HRESETn = 1'b1;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
